// File: rtl/cond_unit.sv
// Conditional-execution stage after the ALU: holds the NZCV flags, evaluates the
// instruction condition field and gates the decoder write strobes.
module cond_unit #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] cond,
  input  logic [1:0] flag_w,
  input  logic       pcs_in,
  input  logic       reg_w_in,
  input  logic       mem_w_in,
  input  logic       no_write,
  input  logic       alu_negative,
  input  logic       alu_zero,
  input  logic       alu_carry,
  input  logic       alu_overflow,
  output logic       cond_ex,
  output logic       pc_src,
  output logic       reg_write,
  output logic       mem_write,
  output logic [3:0] flags,
  output logic       illegal_cond
);

  logic [3:0] flags_q, flags_d;
  logic       n_flag, z_flag, c_flag, v_flag;
  logic       cond_pass;
  logic       commit;

  assign {n_flag, z_flag, c_flag, v_flag} = flags_q;

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = z_flag;
      4'b0001: cond_pass = ~z_flag;
      4'b0010: cond_pass = c_flag;
      4'b0011: cond_pass = ~c_flag;
      4'b0100: cond_pass = n_flag;
      4'b0101: cond_pass = ~n_flag;
      4'b0110: cond_pass = v_flag;
      4'b0111: cond_pass = ~v_flag;
      4'b1000: cond_pass = c_flag & ~z_flag;
      4'b1001: cond_pass = ~c_flag | z_flag;
      4'b1010: cond_pass = (n_flag == v_flag);
      4'b1011: cond_pass = (n_flag != v_flag);
      4'b1100: cond_pass = ~z_flag & (n_flag == v_flag);
      4'b1101: cond_pass = z_flag | (n_flag != v_flag);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign cond_ex      = cond_pass;
  assign commit       = en & cond_pass;
  assign pc_src       = pcs_in & commit;
  assign reg_write    = reg_w_in & ~no_write & commit;
  assign mem_write    = mem_w_in & commit;
  assign illegal_cond = en & (cond == 4'b1111);
  assign flags        = flags_q;

  // Each flag pair updates independently; the evaluation above uses the old flags.
  always_comb begin
    flags_d = flags_q;
    if (commit) begin
      if (flag_w[1]) flags_d[3:2] = {alu_negative, alu_zero};
      if (flag_w[0]) flags_d[1:0] = {alu_carry, alu_overflow};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) flags_q <= RESET_FLAGS;
    else       flags_q <= flags_d;
  end

endmodule
